pipe_stage_skid: RTL

Parametrised pipeline-stage register, the successor to the fixed MEM/WB latch. Adds valid/ready handshaking, back-pressure absorption via an optional one-entry skid buffer, synchronous flush, and bubble insertion that zeroes control fields. It also provides a saturating stall counter. It is instantiated between any two pipeline stages; for MEM/WB the payload is alu_data, read_data, pc_four and rd_addr, and the control field is wb_sel and rd_wren.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_skid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB widths for the handshaked pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int MEMWB_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 3;

  // Field order sets the bit layout of the flat MEM/WB payload vector.
  typedef struct packed {
    logic [31:0] alu_data;
    logic [31:0] read_data;
    logic [31:0] pc_four;
    logic [4:0]  rd_addr;
  } memwb_payload_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional skid entry, flush, control
// masking when idle and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  stage_state_e      state_r;
  stage_state_e      state_nxt_s;
  logic              valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              in_fire_s;
  logic              out_fire_s;
  logic              load_in_s;
  logic              load_skid_s;
  logic              skid_to_main_s;
  logic [DATA_W-1:0] main_data_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_nxt_s;

  assign in_fire_s  = i_valid & o_ready;
  assign out_fire_s = valid_r & i_ready;

  // Next-state and entry-load decode; flush overrides every transition.
  always_comb begin
    state_nxt_s    = state_r;
    load_in_s      = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    if (i_flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = BUSY;
            load_in_s   = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        BUSY: begin
          if (in_fire_s && out_fire_s) begin
            load_in_s = 1'b1;
          end else if (in_fire_s) begin
            state_nxt_s = FULL;
            load_skid_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_nxt_s    = BUSY;
            skid_to_main_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Select the payload/control that the main entry presents next cycle.
  always_comb begin
    main_data_nxt_s = main_data_r;
    main_ctrl_nxt_s = main_ctrl_r;
    if (load_in_s) begin
      main_data_nxt_s = i_data;
      main_ctrl_nxt_s = i_ctrl;
    end else if (skid_to_main_s) begin
      main_data_nxt_s = skid_data_r;
      main_ctrl_nxt_s = skid_ctrl_r;
    end else begin
      main_data_nxt_s = main_data_r;
      main_ctrl_nxt_s = main_ctrl_r;
    end
  end

  // Main entry: control is stored pre-masked so o_ctrl is a plain register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= EMPTY;
      valid_r     <= 1'b0;
      main_data_r <= '0;
      main_ctrl_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      valid_r     <= (state_nxt_s != EMPTY);
      main_data_r <= main_data_nxt_s;
      main_ctrl_r <= (state_nxt_s != EMPTY) ? main_ctrl_nxt_s : {CTRL_W{1'b0}};
    end
  end

  // Skid entry captures the word accepted while downstream is stalled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      skid_data_r <= '0;
      skid_ctrl_r <= '0;
    end else if (load_skid_s) begin
      skid_data_r <= i_data;
      skid_ctrl_r <= i_ctrl;
    end else begin
      skid_data_r <= skid_data_r;
      skid_ctrl_r <= skid_ctrl_r;
    end
  end

  // Stall counter saturates at all-ones and ignores flush.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_r <= '0;
    end else if (valid_r && !i_ready && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  generate
    if (SKID) begin : g_skid_ready
      logic ready_r;
      // Registered ready breaks the combinational path from i_ready.
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          ready_r <= 1'b1;
        end else begin
          ready_r <= (state_nxt_s != FULL);
        end
      end
      assign o_ready = ready_r;
    end else begin : g_comb_ready
      assign o_ready = !valid_r | i_ready;
    end
  endgenerate

  assign o_valid     = valid_r;
  assign o_data      = main_data_r;
  assign o_ctrl      = main_ctrl_r;
  assign o_stall_cnt = stall_cnt_r;

endmodule
